// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: load-use bubbles,
// EX redirect flushes, data-memory wait freezes with timeout, event counters.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_lw,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_stall,
  output logic        exmem_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        mem_err,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH, ERROR} state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT    = 8'(MEM_TIMEOUT);

  state_t     state_reg, state_next;
  logic [2:0] flush_rem_reg, flush_rem_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       mem_err_reg, mem_err_next;

  logic memwait, loaduse;
  logic stall_all, bubble, flush_both, redirect_taken;

  assign memwait = mem_req & ~mem_ready;
  assign loaduse = ex_lw & (ex_rd != 5'd0) &
                   ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_next     = state_reg;
    flush_rem_next = flush_rem_reg;
    wait_cnt_next  = wait_cnt_reg;
    mem_err_next   = mem_err_reg;
    stall_all      = 1'b0;
    bubble         = 1'b0;
    flush_both     = 1'b0;
    redirect_taken = 1'b0;
    case (state_reg)
      RUN: begin
        if (memwait) begin
          stall_all     = 1'b1;
          state_next    = MEM_WAIT;
          wait_cnt_next = 8'd1;
        end else if (ex_redirect) begin
          flush_both     = 1'b1;
          redirect_taken = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_next     = FLUSH;
            flush_rem_next = FLUSH_INIT;
          end
        end else if (loaduse) begin
          bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        // EX is frozen here, so redirects and load-use are not looked at.
        if (memwait) begin
          stall_all     = 1'b1;
          wait_cnt_next = wait_cnt_reg + 8'd1;
          if (wait_cnt_reg + 8'd1 >= TIMEOUT) begin
            state_next   = ERROR;
            mem_err_next = 1'b1;
          end
        end else begin
          state_next = (flush_rem_reg != 3'd0) ? FLUSH : RUN;
        end
      end
      FLUSH: begin
        if (memwait) begin
          stall_all     = 1'b1;
          state_next    = MEM_WAIT;
          wait_cnt_next = 8'd1;
        end else begin
          flush_both     = 1'b1;
          flush_rem_next = flush_rem_reg - 3'd1;
          if (flush_rem_reg <= 3'd1) begin
            state_next     = RUN;
            flush_rem_next = 3'd0;
          end
        end
      end
      ERROR: begin
        stall_all    = 1'b1;
        mem_err_next = 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= RUN;
      flush_rem_reg <= 3'd0;
      wait_cnt_reg  <= 8'd0;
      mem_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      flush_rem_reg <= flush_rem_next;
      wait_cnt_reg  <= wait_cnt_next;
      mem_err_reg   <= mem_err_next;
    end
  end

  // Outputs are forced low while reset is held; a flush overrides a stall.
  assign ifid_flush  = ~reset & flush_both;
  assign idex_flush  = ~reset & (flush_both | bubble);
  assign pc_stall    = ~reset & (stall_all | bubble);
  assign ifid_stall  = ~reset & (stall_all | bubble) & ~ifid_flush;
  assign idex_stall  = ~reset & stall_all & ~idex_flush;
  assign exmem_stall = ~reset & stall_all;
  assign mem_err     = mem_err_reg;

  logic [1:0] cnt_event;
  assign cnt_event = {redirect_taken, pc_stall};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [15:0] count_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          count_reg <= 16'd0;
        else if (cnt_event[gi] && (count_reg != 16'hFFFF))
          count_reg <= count_reg + 16'd1;
      end
    end
  endgenerate

  assign stall_cnt = g_cnt[0].count_reg;
  assign flush_cnt = g_cnt[1].count_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (FLUSH_CYCLES=3/MEM_TIMEOUT=64 and
// FLUSH_CYCLES=1/MEM_TIMEOUT=4) driven together, checked against a cycle model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_lw, ex_redirect, mem_req, mem_ready;

  logic        pc_stall0, ifid_stall0, idex_stall0, exmem_stall0, ifid_flush0, idex_flush0, mem_err0;
  logic        pc_stall1, ifid_stall1, idex_stall1, exmem_stall1, ifid_flush1, idex_flush1, mem_err1;
  logic [15:0] stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(64)) dut0 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_lw(ex_lw),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall0), .ifid_stall(ifid_stall0), .idex_stall(idex_stall0),
    .exmem_stall(exmem_stall0), .ifid_flush(ifid_flush0), .idex_flush(idex_flush0),
    .mem_err(mem_err0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0));

  hazard_ctrl #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(4)) dut1 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_lw(ex_lw),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall1), .ifid_stall(ifid_stall1), .idex_stall(idex_stall1),
    .exmem_stall(exmem_stall1), .ifid_flush(ifid_flush1), .idex_flush(idex_flush1),
    .mem_err(mem_err1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1));

  // Output vector order: {pc, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush}
  logic [5:0]  out_v [2];
  logic [15:0] scnt  [2];
  logic [15:0] fcnt  [2];
  logic        merr  [2];
  assign out_v[0] = {pc_stall0, ifid_stall0, idex_stall0, exmem_stall0, ifid_flush0, idex_flush0};
  assign out_v[1] = {pc_stall1, ifid_stall1, idex_stall1, exmem_stall1, ifid_flush1, idex_flush1};
  assign scnt[0] = stall_cnt0;
  assign scnt[1] = stall_cnt1;
  assign fcnt[0] = flush_cnt0;
  assign fcnt[1] = flush_cnt1;
  assign merr[0] = mem_err0;
  assign merr[1] = mem_err1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state per instance
  int         fc_m [2];
  int         mt_m [2];
  bit         err_m [2];
  bit         waiting_m [2];
  int         waited_m [2];
  int         flush_left_m [2];
  int         stalls_m [2];
  int         flushes_m [2];
  logic [5:0] exp_out [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      err_m[d] = 0; waiting_m[d] = 0; waited_m[d] = 0;
      flush_left_m[d] = 0; stalls_m[d] = 0; flushes_m[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    bit mw, lu;
    logic [5:0] o;
    mw = mem_req && !mem_ready;
    lu = ex_lw && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    o = 6'b000000;
    if (err_m[d]) begin
      o = 6'b111100;
    end else if (waiting_m[d]) begin
      if (mw) begin
        o = 6'b111100;
        waited_m[d]++;
        if (waited_m[d] >= mt_m[d]) err_m[d] = 1;
      end else begin
        waiting_m[d] = 0;
      end
    end else if (mw) begin
      o = 6'b111100;
      waiting_m[d] = 1;
      waited_m[d] = 1;
    end else if (flush_left_m[d] > 0) begin
      o = 6'b000011;
      flush_left_m[d]--;
    end else if (ex_redirect) begin
      o = 6'b000011;
      if (flushes_m[d] < 65535) flushes_m[d]++;
      flush_left_m[d] = fc_m[d] - 1;
    end else if (lu) begin
      o = 6'b110001;
    end
    if (o[5] && stalls_m[d] < 65535) stalls_m[d]++;
    exp_out[d] = o;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic lw, input logic rdr,
                       input logic req, input logic rdy);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_lw = lw; ex_redirect = rdr; mem_req = req; mem_ready = rdy;
  endtask

  // One clock: outputs checked mid-cycle, registered state checked after the edge.
  task automatic step();
    #2;
    for (int d = 0; d < 2; d++) begin
      model_step(d);
      check($sformatf("out%0d", d), 32'(out_v[d]), 32'(exp_out[d]));
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("stall_cnt%0d", d), 32'(scnt[d]), 32'(stalls_m[d]));
      check($sformatf("flush_cnt%0d", d), 32'(fcnt[d]), 32'(flushes_m[d]));
      check($sformatf("mem_err%0d", d), 32'(merr[d]), 32'(err_m[d]));
    end
  endtask

  // Reset is raised between edges so the clear is observed before any clock.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_out%0d", d), 32'(out_v[d]), 32'd0);
      check($sformatf("rst_scnt%0d", d), 32'(scnt[d]), 32'd0);
      check($sformatf("rst_fcnt%0d", d), 32'(fcnt[d]), 32'd0);
      check($sformatf("rst_merr%0d", d), 32'(merr[d]), 32'd0);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit any_wait;
    fc_m[0] = 3; mt_m[0] = 64;
    fc_m[1] = 1; mt_m[1] = 4;
    reset = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    do_reset();

    // Load-use on rs2: one bubble, then clears when ex_lw drops
    drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0); step();
    check("lu_stall_cnt", 32'(scnt[0]), 32'd1);

    // Load to x0 never stalls
    drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); step();
    check("x0_out", 32'(out_v[0]), 32'd0);
    check("x0_stall_cnt", 32'(scnt[0]), 32'd1);

    // Redirect pulse: three flush cycles on dut0, one on dut1
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); step();
    idle();
    repeat (3) step();
    check("redir_fcnt0", 32'(fcnt[0]), 32'd1);
    check("redir_fcnt1", 32'(fcnt[1]), 32'd1);

    // Four wait cycles then ready; dut1 times out on the 4th
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) step();
    check("tmo_merr1", 32'(merr[1]), 32'd1);
    check("tmo_merr0", 32'(merr[0]), 32'd0);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); step();
    idle();
    repeat (2) step();
    check("tmo_stalls1", 32'(out_v[1]), 32'h3C);

    // memwait + redirect + loaduse together: only stalls, no redirect counted
    do_reset();
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0); step();
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1); step();
    check("simul_fcnt0", 32'(fcnt[0]), 32'd0);

    // memwait interrupting a flush sequence resumes the remaining flushes
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); step();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) step();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); step();
    idle();
    repeat (3) step();
    check("fw_fcnt0", 32'(fcnt[0]), 32'd1);

    // Randomised traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ((err_m[1] && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0)
        do_reset();
      any_wait = (waiting_m[0] && !err_m[0]) || (waiting_m[1] && !err_m[1]);
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 4) == 0),
            any_wait ? 1'b1 : 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
